// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU slice.
//   DATA_WIDTH_DEF  default operand/result width
//   UNIT_*          ALU_FUN[3:2] unit-select codes
//   alu_op_e        the sixteen full opcodes
//   CMP_*_CODE      values registered on CMP_OUT when a compare holds
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_NAND = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_NOP  = 4'b1000,
        OP_EQ   = 4'b1001,
        OP_GT   = 4'b1010,
        OP_LT   = 4'b1011,
        OP_SHRA = 4'b1100,
        OP_SHLA = 4'b1101,
        OP_SHRB = 4'b1110,
        OP_SHLB = 4'b1111
    } alu_op_e;

    localparam int CMP_EQ_CODE = 1;
    localparam int CMP_GT_CODE = 2;
    localparam int CMP_LT_CODE = 3;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode bus into the ALU and the registered result bus out.
//   master: drives A, B, ALU_FUN; observes results and flags
//   slave : consumes A, B, ALU_FUN; drives results and flags
interface alu_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [3:0]            ALU_FUN;

    logic [DATA_WIDTH-1:0] Arith_OUT;
    logic                  Carry_OUT;
    logic                  Arith_Flag;
    logic [DATA_WIDTH-1:0] Logic_OUT;
    logic                  Logic_Flag;
    logic [DATA_WIDTH-1:0] Shift_OUT;
    logic                  Shift_Flag;
    logic [DATA_WIDTH-1:0] CMP_OUT;
    logic                  CMP_Flag;

    modport master (
        output A, B, ALU_FUN,
        input  Arith_OUT, Carry_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
               Shift_OUT, Shift_Flag, CMP_OUT, CMP_Flag
    );

    modport slave (
        input  A, B, ALU_FUN,
        output Arith_OUT, Carry_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
               Shift_OUT, Shift_Flag, CMP_OUT, CMP_Flag
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: turns the unit-select field ALU_FUN[3:2] into four one-hot
// unit enables.
//   unit_sel  in   ALU_FUN[3:2]
//   arith_en, logic_en, cmp_en, shift_en  out  exactly one is high
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] unit_sel,
    output logic       arith_en,
    output logic       logic_en,
    output logic       cmp_en,
    output logic       shift_en
);
    assign arith_en = (unit_sel == UNIT_ARITH);
    assign logic_en = (unit_sel == UNIT_LOGIC);
    assign cmp_en   = (unit_sel == UNIT_CMP);
    assign shift_en = (unit_sel == UNIT_SHIFT);
endmodule

// File: rtl/alu_top.sv
// alu_top: single-cycle registered ALU with four units (arith, logic,
// compare, shift). Inputs sampled at a rising CLK edge produce results
// visible right after that edge; only the selected unit drives a non-zero
// result and raises its flag.
//   CLK  in  rising-edge clock
//   RST  in  asynchronous active-high reset, clears every output
//   bus  alu_if.slave  A/B/ALU_FUN in, results and flags out
module alu_top
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic CLK,
    input logic RST,
    alu_if.slave bus
);
    logic arith_en, logic_en, cmp_en, shift_en;

    alu_decoder u_dec (
        .unit_sel (bus.ALU_FUN[3:2]),
        .arith_en (arith_en),
        .logic_en (logic_en),
        .cmp_en   (cmp_en),
        .shift_en (shift_en)
    );

    logic [DATA_WIDTH-1:0] a, b;
    assign a = bus.A;
    assign b = bus.B;

    // One extra bit keeps the add carry-out and the subtract borrow; the
    // borrow bit of the zero-extended difference is set exactly when a < b.
    logic [DATA_WIDTH:0] add_full, sub_full;
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    logic [DATA_WIDTH-1:0] arith_d, logic_d, cmp_d, shift_d;
    logic                  carry_d;

    always_comb begin
        arith_d = '0;
        carry_d = 1'b0;
        logic_d = '0;
        cmp_d   = '0;
        shift_d = '0;
        case (bus.ALU_FUN)
            OP_ADD:  {carry_d, arith_d} = add_full;
            OP_SUB:  {carry_d, arith_d} = sub_full;
            OP_MUL:  arith_d = a * b;
            OP_DIV:  arith_d = (b == '0) ? '0 : a / b;
            OP_AND:  logic_d = a & b;
            OP_OR:   logic_d = a | b;
            OP_NAND: logic_d = ~(a & b);
            OP_NOR:  logic_d = ~(a | b);
            OP_NOP:  cmp_d = '0;
            OP_EQ:   cmp_d = (a == b) ? DATA_WIDTH'(CMP_EQ_CODE) : '0;
            OP_GT:   cmp_d = (a > b)  ? DATA_WIDTH'(CMP_GT_CODE) : '0;
            OP_LT:   cmp_d = (a < b)  ? DATA_WIDTH'(CMP_LT_CODE) : '0;
            OP_SHRA: shift_d = a >> 1;
            OP_SHLA: shift_d = a << 1;
            OP_SHRB: shift_d = b >> 1;
            OP_SHLB: shift_d = b << 1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.Arith_OUT  <= '0;
            bus.Carry_OUT  <= 1'b0;
            bus.Arith_Flag <= 1'b0;
            bus.Logic_OUT  <= '0;
            bus.Logic_Flag <= 1'b0;
            bus.CMP_OUT    <= '0;
            bus.CMP_Flag   <= 1'b0;
            bus.Shift_OUT  <= '0;
            bus.Shift_Flag <= 1'b0;
        end else begin
            bus.Arith_OUT  <= arith_d;
            bus.Carry_OUT  <= carry_d;
            bus.Arith_Flag <= arith_en;
            bus.Logic_OUT  <= logic_d;
            bus.Logic_Flag <= logic_en;
            bus.CMP_OUT    <= cmp_d;
            bus.CMP_Flag   <= cmp_en;
            bus.Shift_OUT  <= shift_d;
            bus.Shift_Flag <= shift_en;
        end
    end
endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top (DATA_WIDTH = 16). Each test
// drives a list of operations back to back, pushes the expected register
// image when it drives, and pops/compares one cycle later.
module tb_alu_top;
    import alu_pkg::*;

    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    alu_if #(.DATA_WIDTH(DW)) bus ();

    alu_top #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // flags ordered {Arith, Logic, CMP, Shift}
    typedef struct packed {
        logic [3:0]    flags;
        logic          carry_o;
        logic [DW-1:0] arith_o;
        logic [DW-1:0] logic_o;
        logic [DW-1:0] cmp_o;
        logic [DW-1:0] shift_o;
    } exp_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic          carry;
    } stim_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic stim_t st(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                                 logic [DW-1:0] res, logic carry);
        stim_t s;
        s.op = op; s.a = a; s.b = b; s.res = res; s.carry = carry;
        return s;
    endfunction

    // Place the primary result in the selected unit's field; all else zero.
    function automatic exp_t mk_exp(logic [3:0] op, logic [DW-1:0] res, logic carry);
        exp_t e = '0;
        case (op[3:2])
            2'b00: begin e.flags = 4'b1000; e.arith_o = res; e.carry_o = carry; end
            2'b01: begin e.flags = 4'b0100; e.logic_o = res; end
            2'b10: begin e.flags = 4'b0010; e.cmp_o   = res; end
            default: begin e.flags = 4'b0001; e.shift_o = res; end
        endcase
        return e;
    endfunction

    // Independent reference used for the random sweep.
    function automatic stim_t model(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        logic [DW:0]     s17;
        logic [2*DW-1:0] p;
        logic [DW-1:0]   r = '0;
        logic            c = 1'b0;
        case (op)
            4'd0:  begin s17 = {1'b0, a} + {1'b0, b}; r = s17[DW-1:0]; c = s17[DW]; end
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  begin p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b}; r = p[DW-1:0]; end
            4'd3:  r = (b == 0) ? '0 : a / b;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = ~(a & b);
            4'd7:  r = ~(a | b);
            4'd8:  r = '0;
            4'd9:  r = (a == b) ? 16'd1 : 16'd0;
            4'd10: r = (a > b)  ? 16'd2 : 16'd0;
            4'd11: r = (a < b)  ? 16'd3 : 16'd0;
            4'd12: r = {1'b0, a[DW-1:1]};
            4'd13: r = {a[DW-2:0], 1'b0};
            4'd14: r = {1'b0, b[DW-1:1]};
            default: r = {b[DW-2:0], 1'b0};
        endcase
        return st(op, a, b, r, c);
    endfunction

    function automatic exp_t sample();
        exp_t o;
        o.flags   = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
        o.carry_o = bus.Carry_OUT;
        o.arith_o = bus.Arith_OUT;
        o.logic_o = bus.Logic_OUT;
        o.cmp_o   = bus.CMP_OUT;
        o.shift_o = bus.Shift_OUT;
        return o;
    endfunction

    // Drive one operation, push its expectation, advance past the edge.
    task automatic drive(input stim_t s);
        bus.A = s.a;
        bus.B = s.b;
        bus.ALU_FUN = s.op;
        sb.push_back(mk_exp(s.op, s.res, s.carry));
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t o;
        exp_t e;
        bus.A = 16'd1; bus.B = 16'd1; bus.ALU_FUN = OP_ADD;
        #1 RST = 1'b1;
        #1 o = sample();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_async got=%h want=0", o); end
        @(posedge CLK); #1 o = sample();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_hold got=%h want=0", o); end
        #2 RST = 1'b0;
        #1 o = sample();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_release_pre_edge got=%h want=0", o); end
        sb.push_back(mk_exp(OP_ADD, 16'd2, 1'b0));
        @(posedge CLK); #1 o = sample(); e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_first_result got=%h want=%h", o, e); end
        // mid-operation reset: a held result is cleared before the next edge
        #2 RST = 1'b1;
        #1 o = sample();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_mid_op got=%h want=0", o); end
        #1 RST = 1'b0;
        sb.push_back(mk_exp(OP_ADD, 16'd2, 1'b0));
        @(posedge CLK); #1 o = sample(); e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_mid_recover got=%h want=%h", o, e); end
    endtask

    task automatic test_arith();
        stim_t l[$];
        exp_t  o, e;
        l.push_back(st(OP_ADD, 16'd217,  16'd109,  16'd326,  1'b0));
        l.push_back(st(OP_ADD, 16'h8FFF, 16'h8FBA, 16'h1FB9, 1'b1));
        l.push_back(st(OP_SUB, 16'h8FFF, 16'h8FBA, 16'd69,   1'b0));
        l.push_back(st(OP_SUB, 16'd3,    16'd5,    16'hFFFE, 1'b1));
        l.push_back(st(OP_MUL, 16'h8FFF, 16'h8FBA, 16'd4166, 1'b0));
        l.push_back(st(OP_DIV, 16'd36,   16'd6,    16'd6,    1'b0));
        l.push_back(st(OP_DIV, 16'd5,    16'd0,    16'd0,    1'b0));
        l.push_back(st(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1));
        foreach (l[i]) begin
            drive(l[i]);
            o = sample(); e = sb.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL arith[%0d] op=%b got=%h want=%h", i, l[i].op, o, e); end
        end
    endtask

    task automatic test_logic();
        stim_t l[$];
        exp_t  o, e;
        l.push_back(st(OP_AND,  16'hB6, 16'h6C, 16'h0024, 1'b0));
        l.push_back(st(OP_OR,   16'hB6, 16'h6C, 16'h00FE, 1'b0));
        l.push_back(st(OP_NAND, 16'hB6, 16'h6C, 16'hFFDB, 1'b0));
        l.push_back(st(OP_NOR,  16'hB6, 16'h6C, 16'hFF01, 1'b0));
        foreach (l[i]) begin
            drive(l[i]);
            o = sample(); e = sb.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL logic[%0d] op=%b got=%h want=%h", i, l[i].op, o, e); end
        end
    endtask

    task automatic test_compare();
        stim_t l[$];
        exp_t  o, e;
        l.push_back(st(OP_NOP, 16'd9, 16'd3, 16'd0, 1'b0));
        l.push_back(st(OP_EQ,  16'd4, 16'd4, 16'd1, 1'b0));
        l.push_back(st(OP_EQ,  16'd4, 16'd5, 16'd0, 1'b0));
        l.push_back(st(OP_GT,  16'd5, 16'd2, 16'd2, 1'b0));
        l.push_back(st(OP_LT,  16'd5, 16'd7, 16'd3, 1'b0));
        l.push_back(st(OP_LT,  16'd7, 16'd5, 16'd0, 1'b0));
        l.push_back(st(OP_GT,  16'h8000, 16'h7FFF, 16'd2, 1'b0));
        foreach (l[i]) begin
            drive(l[i]);
            o = sample(); e = sb.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL cmp[%0d] op=%b got=%h want=%h", i, l[i].op, o, e); end
        end
    endtask

    task automatic test_shift();
        stim_t l[$];
        exp_t  o, e;
        l.push_back(st(OP_SHRA, 16'h32,   16'h32, 16'h19,   1'b0));
        l.push_back(st(OP_SHLA, 16'h32,   16'h32, 16'h64,   1'b0));
        l.push_back(st(OP_SHRB, 16'h32,   16'h32, 16'h19,   1'b0));
        l.push_back(st(OP_SHLB, 16'h32,   16'h32, 16'h64,   1'b0));
        l.push_back(st(OP_SHLA, 16'h8001, 16'h0,  16'h0002, 1'b0));
        l.push_back(st(OP_SHRB, 16'h0,    16'h8001, 16'h4000, 1'b0));
        foreach (l[i]) begin
            drive(l[i]);
            o = sample(); e = sb.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL shift[%0d] op=%b got=%h want=%h", i, l[i].op, o, e); end
        end
    endtask

    // Inputs changed between edges must not reach the outputs early.
    task automatic test_hold();
        exp_t o, e;
        drive(st(OP_ADD, 16'd10, 16'd20, 16'd30, 1'b0));
        e = sb.pop_front();
        bus.A = 16'd7; bus.B = 16'd7; bus.ALU_FUN = OP_EQ;
        #3 o = sample();
        checks++;
        if (o !== e) begin errors++; $display("FAIL hold_between_edges got=%h want=%h", o, e); end
        sb.push_back(mk_exp(OP_EQ, 16'd1, 1'b0));
        @(posedge CLK); #1 o = sample(); e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL hold_next_edge got=%h want=%h", o, e); end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        stim_t s;
        for (int i = 0; i < 48; i++) begin
            s = model(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
            if (i % 8 == 0) s = model(s.op, s.a, s.a);
            if (i % 11 == 0) s = model(4'd3, s.a, 16'd0);
            drive(s);
            o = sample(); e = sb.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rand[%0d] op=%b a=%h b=%h got=%h want=%h", i, s.op, s.a, s.b, o, e); end
        end
    endtask

    initial begin
        bus.A = '0; bus.B = '0; bus.ALU_FUN = '0;
        test_reset();
        test_arith();
        test_logic();
        test_compare();
        test_shift();
        test_hold();
        test_back_to_back();
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
